// File: rtl/mips_wb_stage.sv
// mips_wb_stage: writeback stage of the MIPS pipeline, driving the register
// file write port.
//
// Accepts retiring instructions from MEM over valid/ready. ALU results are
// written one cycle after acceptance. Loads either complete in the accept
// cycle (data already valid) or park in WAIT_MEM until mem_rvalid arrives.
// The parked destination is exported to the hazard unit as pend_valid/pend_reg.
//
// Optional feature macro: WB_SUBWORD_EN
//   defined     - lb/lbu/lh/lhu lane select and extension, misaligned loads
//                 are dropped with a one-cycle align_err pulse.
//   not defined - every load is a full word write of mem_rdata; in_ldtype and
//                 in_addr_lo are ignored and align_err stays 0.
//
// State table:
//   state      | meaning
//   S_IDLE     | ready for a new instruction (in_ready=1)
//   S_WAIT_MEM | load accepted, waiting for mem_rvalid (in_ready=0, pend_valid=1)

module mips_wb_stage #(
  parameter int          CNT_W  = 32,
  parameter logic [31:0] RST_PC = 32'h0
) (
  input  logic             CLK,
  input  logic             clrn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_we,
  input  logic             in_m2reg,
  input  logic [4:0]       in_wreg,
  input  logic [31:0]      in_alu,
  input  logic [2:0]       in_ldtype,
  input  logic [1:0]       in_addr_lo,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_rvalid,
  input  logic             flush,
  output logic             WE,
  output logic [4:0]       WriteReg,
  output logic [31:0]      WriteData,
  output logic             pend_valid,
  output logic [4:0]       pend_reg,
  output logic             align_err,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } state_t;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  state_t      state;

  // Captured attributes of a load parked in WAIT_MEM.
  logic        cap_we;
  logic [4:0]  cap_wreg;
  logic [2:0]  cap_ldtype;
  logic [1:0]  cap_lo;

  // Attributes of the load completing this cycle: straight from MEM when the
  // data arrives in the accept cycle, otherwise from the captured copy.
  logic        cur_we;
  logic [4:0]  cur_wreg;
  logic [2:0]  cur_ldtype;
  logic [1:0]  cur_lo;

  logic        accept;
  logic        alu_write;
  logic        ld_fire;
  logic        ld_write;
  logic        ld_misalign;
  logic [31:0] ld_data;

  // No PC is tracked in this stage; the parameter exists only for interface
  // compatibility with the other pipeline stages.
  logic [31:0] unused_rst_pc;
  assign unused_rst_pc = RST_PC;

  // Handshake and completion decode.
  always_comb begin
    in_ready   = (state == S_IDLE);
    accept     = in_valid & in_ready & ~flush;
    cur_we     = (state == S_WAIT_MEM) ? cap_we     : in_we;
    cur_wreg   = (state == S_WAIT_MEM) ? cap_wreg   : in_wreg;
    cur_ldtype = (state == S_WAIT_MEM) ? cap_ldtype : in_ldtype;
    cur_lo     = (state == S_WAIT_MEM) ? cap_lo     : in_addr_lo;

    // Flush in WAIT_MEM wins over data arriving in the same cycle.
    alu_write  = accept & ~in_m2reg & in_we & (in_wreg != 5'd0);
    ld_fire    = (accept & in_m2reg & mem_rvalid)
               | ((state == S_WAIT_MEM) & ~flush & mem_rvalid);
    ld_write   = ld_fire & ~ld_misalign & cur_we & (cur_wreg != 5'd0);
  end

`ifdef WB_SUBWORD_EN
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lane select and sign/zero extension of the load word.
  always_comb begin
    case (cur_lo)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = cur_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    ld_data     = mem_rdata;
    ld_misalign = 1'b0;
    case (cur_ldtype)
      LD_LB:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU: ld_data = {24'h0, byte_sel};
      LD_LH: begin
        ld_data     = {{16{half_sel[15]}}, half_sel};
        ld_misalign = cur_lo[0];
      end
      LD_LHU: begin
        ld_data     = {16'h0, half_sel};
        ld_misalign = cur_lo[0];
      end
      default: begin
        // LD_LW and the reserved encodings behave as a word load.
        ld_data     = mem_rdata;
        ld_misalign = (cur_lo != 2'd0);
      end
    endcase
  end
`else
  // Word-only build: load type and address lane carry no meaning here.
  logic unused_subword;
  assign unused_subword = ^{cur_ldtype, cur_lo, LD_LW, LD_LB, LD_LBU, LD_LH, LD_LHU};

  // Loads always write the full memory word.
  always_comb begin
    ld_data     = mem_rdata;
    ld_misalign = 1'b0;
  end
`endif

  // Writeback FSM with registered regfile port, hazard outputs and counter.
  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      state      <= S_IDLE;
      cap_we     <= 1'b0;
      cap_wreg   <= 5'd0;
      cap_ldtype <= LD_LW;
      cap_lo     <= 2'd0;
      WE         <= 1'b0;
      WriteReg   <= 5'd0;
      WriteData  <= 32'h0;
      pend_valid <= 1'b0;
      align_err  <= 1'b0;
      retire_cnt <= '0;
    end else begin
      WE        <= 1'b0;
      align_err <= 1'b0;

      // WriteReg/WriteData only move when a write actually retires.
      if (alu_write || ld_write) begin
        WE         <= 1'b1;
        WriteReg   <= alu_write ? in_wreg : cur_wreg;
        WriteData  <= alu_write ? in_alu  : ld_data;
        retire_cnt <= retire_cnt + 1'b1;
      end

      if (ld_fire && ld_misalign) begin
        align_err <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (accept && in_m2reg && !mem_rvalid) begin
            cap_we     <= in_we;
            cap_wreg   <= in_wreg;
            cap_ldtype <= in_ldtype;
            cap_lo     <= in_addr_lo;
            pend_valid <= 1'b1;
            state      <= S_WAIT_MEM;
          end
        end
        S_WAIT_MEM: begin
          if (flush || mem_rvalid) begin
            pend_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          pend_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  assign pend_reg = cap_wreg;

endmodule

// File: tb/tb_mips_wb_stage.sv
// Directed testbench for mips_wb_stage (CNT_W=4 so counter wrap is reachable).
// Expected values follow the WB_SUBWORD_EN setting of the build.

module tb_mips_wb_stage;

  logic        CLK = 1'b0;
  logic        clrn;
  logic        in_valid, in_ready, in_we, in_m2reg;
  logic [4:0]  in_wreg;
  logic [31:0] in_alu;
  logic [2:0]  in_ldtype;
  logic [1:0]  in_addr_lo;
  logic [31:0] mem_rdata;
  logic        mem_rvalid, flush;
  logic        WE;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        pend_valid;
  logic [4:0]  pend_reg;
  logic        align_err;
  logic [3:0]  retire_cnt;

  int total   = 0;
  int bad     = 0;
  int exp_cnt = 0;

  mips_wb_stage #(.CNT_W(4), .RST_PC(32'h0)) dut (
    .CLK(CLK), .clrn(clrn),
    .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_m2reg(in_m2reg),
    .in_wreg(in_wreg), .in_alu(in_alu), .in_ldtype(in_ldtype), .in_addr_lo(in_addr_lo),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .flush(flush),
    .WE(WE), .WriteReg(WriteReg), .WriteData(WriteData),
    .pend_valid(pend_valid), .pend_reg(pend_reg), .align_err(align_err),
    .retire_cnt(retire_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid   = 1'b0;
    in_we      = 1'b0;
    in_m2reg   = 1'b0;
    in_wreg    = 5'd0;
    in_alu     = 32'h0;
    in_ldtype  = 3'd0;
    in_addr_lo = 2'd0;
    mem_rdata  = 32'h0;
    mem_rvalid = 1'b0;
    flush      = 1'b0;
  endtask

  // One accepted instruction; returns with inputs idle, #1 after the accept edge.
  task automatic send(input logic m2reg, input logic we, input logic [4:0] wreg,
                      input logic [31:0] alu, input logic [2:0] ldt, input logic [1:0] lo,
                      input logic rv, input logic [31:0] rd);
    in_valid   = 1'b1;
    in_m2reg   = m2reg;
    in_we      = we;
    in_wreg    = wreg;
    in_alu     = alu;
    in_ldtype  = ldt;
    in_addr_lo = lo;
    mem_rvalid = rv;
    mem_rdata  = rd;
    tick();
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clrn = 1'b0;
    idle_inputs();
    tick();
    tick();
    check("rst_we", WE, 0);
    check("rst_wreg", WriteReg, 0);
    check("rst_wdata", WriteData, 0);
    check("rst_pend", pend_valid, 0);
    check("rst_pend_reg", pend_reg, 0);
    check("rst_align", align_err, 0);
    check("rst_cnt", retire_cnt, 0);
    check("rst_ready", in_ready, 1);
    #3 clrn = 1'b1;
    tick();

    // ALU write, latency 1
    send(1'b0, 1'b1, 5'd5, 32'h1234, 3'd0, 2'd0, 1'b0, 32'h0);
    exp_cnt++;
    check("alu_we", WE, 1);
    check("alu_wreg", WriteReg, 5);
    check("alu_wdata", WriteData, 32'h1234);
    check("alu_cnt", retire_cnt, exp_cnt % 16);
    tick();
    check("alu_we_pulse", WE, 0);
    check("alu_wdata_hold", WriteData, 32'h1234);

    // lb lane 2, data three cycles late
    send(1'b1, 1'b1, 5'd7, 32'h0, 3'd1, 2'd2, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("wait_pend", pend_valid, 1);
      check("wait_pend_reg", pend_reg, 7);
      check("wait_ready", in_ready, 0);
      check("wait_we", WE, 0);
      tick();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0080FF00;
    tick();
    idle_inputs();
    exp_cnt++;
    check("lb_we", WE, 1);
    check("lb_wreg", WriteReg, 7);
`ifdef WB_SUBWORD_EN
    check("lb_wdata", WriteData, 32'hFFFFFF80);
`else
    check("lb_wdata", WriteData, 32'h0080FF00);
`endif
    check("lb_pend_clr", pend_valid, 0);
    check("lb_ready", in_ready, 1);
    check("lb_cnt", retire_cnt, exp_cnt % 16);

    // lbu, data in the accept cycle
    send(1'b1, 1'b1, 5'd8, 32'h0, 3'd2, 2'd2, 1'b1, 32'h0080FF00);
    exp_cnt++;
    check("lbu_we", WE, 1);
    check("lbu_pend", pend_valid, 0);
`ifdef WB_SUBWORD_EN
    check("lbu_wdata", WriteData, 32'h00000080);
`else
    check("lbu_wdata", WriteData, 32'h0080FF00);
`endif

    // lh upper half, lhu lower half
    send(1'b1, 1'b1, 5'd9, 32'h0, 3'd3, 2'd2, 1'b1, 32'h80010000);
    exp_cnt++;
`ifdef WB_SUBWORD_EN
    check("lh_wdata", WriteData, 32'hFFFF8001);
`else
    check("lh_wdata", WriteData, 32'h80010000);
`endif
    send(1'b1, 1'b1, 5'd9, 32'h0, 3'd4, 2'd0, 1'b1, 32'h1234F00D);
    exp_cnt++;
`ifdef WB_SUBWORD_EN
    check("lhu_wdata", WriteData, 32'h0000F00D);
`else
    check("lhu_wdata", WriteData, 32'h1234F00D);
`endif
    check("lhu_cnt", retire_cnt, exp_cnt % 16);

    // Misaligned lh and lw
    send(1'b1, 1'b1, 5'd10, 32'h0, 3'd3, 2'd1, 1'b1, 32'hAABBCCDD);
`ifdef WB_SUBWORD_EN
    check("mis_lh_we", WE, 0);
    check("mis_lh_err", align_err, 1);
    check("mis_lh_wdata_hold", WriteData, 32'h0000F00D);
`else
    exp_cnt++;
    check("mis_lh_we", WE, 1);
    check("mis_lh_err", align_err, 0);
    check("mis_lh_wdata", WriteData, 32'hAABBCCDD);
`endif
    check("mis_lh_cnt", retire_cnt, exp_cnt % 16);
    tick();
    check("mis_err_pulse", align_err, 0);
    send(1'b1, 1'b1, 5'd11, 32'h0, 3'd0, 2'd2, 1'b1, 32'h55667788);
`ifdef WB_SUBWORD_EN
    check("mis_lw_we", WE, 0);
    check("mis_lw_err", align_err, 1);
`else
    exp_cnt++;
    check("mis_lw_we", WE, 1);
    check("mis_lw_wdata", WriteData, 32'h55667788);
`endif

    // Flush in WAIT_MEM beats same-cycle data
    send(1'b1, 1'b1, 5'd12, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0);
    check("fl_pend", pend_valid, 1);
    flush      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    tick();
    idle_inputs();
    check("fl_we", WE, 0);
    check("fl_ready", in_ready, 1);
    check("fl_pend_clr", pend_valid, 0);
    check("fl_cnt", retire_cnt, exp_cnt % 16);
    tick();
    check("fl_we_late", WE, 0);

    // Flush with in_valid in IDLE drops the instruction
    flush = 1'b1;
    send(1'b0, 1'b1, 5'd13, 32'hCAFE, 3'd0, 2'd0, 1'b0, 32'h0);
    check("fl_idle_we", WE, 0);

    // r0 destination and in_we=0 never write
    send(1'b0, 1'b1, 5'd0, 32'h9999, 3'd0, 2'd0, 1'b0, 32'h0);
    check("r0_we", WE, 0);
    check("r0_cnt", retire_cnt, exp_cnt % 16);
    send(1'b0, 1'b0, 5'd3, 32'h9999, 3'd0, 2'd0, 1'b0, 32'h0);
    check("nowe_we", WE, 0);

    // Stray mem_rvalid in IDLE ignored
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11111111;
    tick();
    idle_inputs();
    check("stray_we", WE, 0);
    check("stray_pend", pend_valid, 0);

    // Back-to-back ALU writes through the 4-bit counter wrap
    in_valid = 1'b1;
    in_we    = 1'b1;
    in_wreg  = 5'd1;
    for (int i = 0; i < 16; i++) begin
      in_alu = 32'h100 + i;
      tick();
      exp_cnt++;
      check("wrap_we", WE, 1);
      check("wrap_cnt", retire_cnt, exp_cnt % 16);
    end
    idle_inputs();
    check("wrap_wdata", WriteData, 32'h10F);

    // Async reset while a load is parked
    send(1'b1, 1'b1, 5'd20, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0);
    check("ar_pend", pend_valid, 1);
    #2 clrn = 1'b0;
    #1;
    check("ar_pend_clr", pend_valid, 0);
    check("ar_pend_reg", pend_reg, 0);
    check("ar_ready", in_ready, 1);
    check("ar_wreg", WriteReg, 0);
    check("ar_wdata", WriteData, 0);
    check("ar_cnt", retire_cnt, 0);
    #1 clrn = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h77777777;
    tick();
    idle_inputs();
    check("ar_lost_we", WE, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
